// File: rtl/lsu_pkg.sv
// Shared types and address-map defaults for the memory-stage LSU.
// Straddle splitting is enabled by LSU_MISALIGN_SPLIT_EN.
package lsu_pkg;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } lsu_state_e;

   localparam int unsigned LSU_DMEM_WORDS   = 512;
   localparam logic [31:0] LSU_IO_LEDR_ADDR = 32'h0000_7000;
   localparam logic [31:0] LSU_IO_SW_ADDR   = 32'h0000_7800;

   // Enables over a two-word window; bits [7:4] land in the next word.
   function automatic logic [7:0] lsu_byte_en(
      input logic [2:0] f3,
      input logic [1:0] off
   );
      logic [7:0] base;
      case (f3[1:0])
         2'b00:   base = 8'b0000_0001;
         2'b01:   base = 8'b0000_0011;
         default: base = 8'b0000_1111;
      endcase
      return base << off;
   endfunction

endpackage

// File: rtl/lsu_memory_stage_if.sv
// EX/MEM-side request bus and MEM-side load/stall response.
interface lsu_memory_stage_if;

   logic        mem_rdenM;
   logic        mem_wrenM;
   logic [2:0]  funct3M;
   logic [31:0] alu_dataM;
   logic [31:0] st_dataM;
   logic [31:0] ld_dataM;
   logic        stallM;

   modport master (
      output mem_rdenM, mem_wrenM, funct3M,
      output alu_dataM, st_dataM,
      input  ld_dataM, stallM
   );

   modport slave (
      input  mem_rdenM, mem_wrenM, funct3M,
      input  alu_dataM, st_dataM,
      output ld_dataM, stallM
   );

endinterface

// File: rtl/lsu_dmem.sv
// Byte-enabled data memory with two combinational word read ports.
module lsu_dmem #(
   parameter int unsigned DMEM_WORDS = 512,
   parameter int unsigned AW         = $clog2(DMEM_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [3:0]    wbe,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr0,
   input  logic [AW-1:0] raddr1,
   output logic [31:0]   rdata0,
   output logic [31:0]   rdata1
);

   logic [31:0] mem_q [DMEM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wbe[b]) begin
               mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata0 = mem_q[raddr0];
   assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/lsu_memory_stage.sv
// RV32I memory-stage LSU: DMEM, LEDR/SW registers, straddle splitting.
// Splitting into two aligned cycles is built with LSU_MISALIGN_SPLIT_EN.
module lsu_memory_stage
   import lsu_pkg::*;
#(
   parameter int unsigned DMEM_WORDS   = LSU_DMEM_WORDS,
   parameter logic [31:0] IO_LEDR_ADDR = LSU_IO_LEDR_ADDR,
   parameter logic [31:0] IO_SW_ADDR   = LSU_IO_SW_ADDR
) (
   input  logic                     clk,
   input  logic                     aclr,
   lsu_memory_stage_if.slave        bus,
   input  logic [31:0]              io_sw,
   output logic [31:0]              io_ledr
);

   localparam int unsigned AW = $clog2(DMEM_WORDS);
   localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

   logic          rd, wr;
   logic          is_dmem, is_ledr, is_sw;
   logic [1:0]    off;
   logic [4:0]    sh;
   logic [AW-1:0] w, w1;
   logic [7:0]    be64;
   logic [3:0]    be_rot;
   logic [63:0]   data64;
   logic [31:0]   data_rot;
   logic [31:0]   rd0, rd_next, src;
   logic [63:0]   win, win_sh;
   logic [31:0]   raw, ext;
   logic          we;
   logic [AW-1:0] waddr;
   logic [3:0]    wbe;
   logic [31:0]   wdata;
   logic          stall;
   logic [31:0]   io_ledr_q, io_ledr_d;

   assign rd = bus.mem_rdenM;
   assign wr = bus.mem_wrenM;
   assign off = bus.alu_dataM[1:0];
   assign sh = {off, 3'b000};
   assign w = bus.alu_dataM[AW+1:2];
   assign w1 = w + AW'(1);

   assign is_dmem = bus.alu_dataM < DMEM_BYTES;
   assign is_ledr = !is_dmem &&
      (bus.alu_dataM[31:2] == IO_LEDR_ADDR[31:2]);
   assign is_sw = !is_dmem && !is_ledr &&
      (bus.alu_dataM[31:2] == IO_SW_ADDR[31:2]);

   // Unsplit accesses fold the upper half back into the same word.
   assign be64 = lsu_byte_en(bus.funct3M, off);
   assign be_rot = be64[3:0] | be64[7:4];
   assign data64 = {32'b0, bus.st_dataM} << sh;
   assign data_rot = data64[31:0] | data64[63:32];

   lsu_dmem #(
      .DMEM_WORDS(DMEM_WORDS),
      .AW        (AW)
   ) u_dmem (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wbe   (wbe),
      .wdata (wdata),
      .raddr0(w),
      .raddr1(w1),
      .rdata0(rd0),
      .rdata1(rd_next)
   );

   always_comb begin
      src = '0;
      if (is_dmem) src = rd0;
      else if (is_ledr) src = io_ledr_q;
      else if (is_sw) src = io_sw;
   end

`ifdef LSU_MISALIGN_SPLIT_EN
   lsu_state_e  state_q, state_d;
   logic [31:0] hold_q, hold_d;
   logic        split_acc;

   assign split_acc = is_dmem && (rd || wr) && (be64[7:4] != 4'b0);

   always_comb begin
      state_d = state_q;
      hold_d = hold_q;
      stall = 1'b0;
      we = 1'b0;
      waddr = w;
      wbe = be_rot;
      wdata = data_rot;
      win = {src, src};
      unique case (state_q)
         IDLE: begin
            if (split_acc) begin
               stall = 1'b1;
               hold_d = rd0;
               state_d = SPLIT;
               we = wr;
               wbe = be64[3:0];
               wdata = data64[31:0];
            end else begin
               we = wr && is_dmem;
            end
         end
         SPLIT: begin
            state_d = IDLE;
            win = {rd_next, hold_q};
            we = wr;
            waddr = w1;
            wbe = be64[7:4];
            wdata = data64[63:32];
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state_q <= IDLE;
         hold_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q <= hold_d;
      end
   end
`else
   logic unused_next;
   assign unused_next = ^rd_next;
   assign stall = 1'b0;

   always_comb begin
      we = wr && is_dmem;
      waddr = w;
      wbe = be_rot;
      wdata = data_rot;
      win = {src, src};
   end
`endif

   assign win_sh = win >> sh;
   assign raw = win_sh[31:0];

   always_comb begin
      unique case (bus.funct3M)
         F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
         F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
         F3_BU:   ext = {24'b0, raw[7:0]};
         F3_HU:   ext = {16'b0, raw[15:0]};
         default: ext = raw;
      endcase
   end

   always_comb begin
      io_ledr_d = io_ledr_q;
      if (wr && is_ledr) begin
         for (int b = 0; b < 4; b++) begin
            if (be_rot[b]) io_ledr_d[8*b +: 8] = data_rot[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) io_ledr_q <= '0;
      else io_ledr_q <= io_ledr_d;
   end

   // A store wins over a simultaneous load, which then returns zero.
   assign bus.ld_dataM = (rd && !wr) ? ext : 32'b0;
   assign bus.stallM = stall;
   assign io_ledr = io_ledr_q;

endmodule

// File: tb/tb_lsu_memory_stage.sv
// Directed bench for lsu_memory_stage; expectations follow
// whether LSU_MISALIGN_SPLIT_EN is defined for the build.
module tb_lsu_memory_stage;

   logic        clk;
   logic        aclr;
   logic [31:0] io_sw;
   logic [31:0] io_ledr;
   int          checks;
   int          errors;

   lsu_memory_stage_if bus ();

   lsu_memory_stage dut (
      .clk    (clk),
      .aclr   (aclr),
      .bus    (bus),
      .io_sw  (io_sw),
      .io_ledr(io_ledr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   task automatic idle();
      bus.mem_rdenM = 1'b0;
      bus.mem_wrenM = 1'b0;
      bus.funct3M = 3'b010;
      bus.alu_dataM = '0;
      bus.st_dataM = '0;
   endtask

   task automatic store(input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        output bit st);
      @(negedge clk);
      bus.mem_rdenM = 1'b0;
      bus.mem_wrenM = 1'b1;
      bus.funct3M = f3;
      bus.alu_dataM = a;
      bus.st_dataM = d;
      #1;
      st = bus.stallM;
      @(posedge clk);
      if (st) @(posedge clk);
      #1;
      idle();
   endtask

   task automatic load(input logic [2:0] f3,
                       input logic [31:0] a,
                       output logic [31:0] q,
                       output bit st);
      @(negedge clk);
      bus.mem_rdenM = 1'b1;
      bus.mem_wrenM = 1'b0;
      bus.funct3M = f3;
      bus.alu_dataM = a;
      #1;
      st = bus.stallM;
      if (st) begin
         @(posedge clk);
         #1;
      end
      q = bus.ld_dataM;
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic test_reset();
      checks++;
      if (bus.stallM !== 1'b0) begin
         errors++;
         $display("FAIL rst_stall: got %b expected 0", bus.stallM);
      end
      checks++;
      if (io_ledr !== 32'h0) begin
         errors++;
         $display("FAIL rst_ledr: got %h expected 0", io_ledr);
      end
      checks++;
      if (bus.ld_dataM !== 32'h0) begin
         errors++;
         $display("FAIL rst_ld: got %h expected 0", bus.ld_dataM);
      end
   endtask

   task automatic test_aligned();
      logic [31:0] q;
      bit s, sa;
      store(3'b010, 32'h10, 32'hDEAD_BEEF, s);
      sa = s;
      load(3'b000, 32'h13, q, s);
      sa |= s;
      checks++;
      if (q !== 32'hFFFF_FFDE) begin
         errors++;
         $display("FAIL lb_13: got %h expected ffffffde", q);
      end
      load(3'b100, 32'h13, q, s);
      sa |= s;
      checks++;
      if (q !== 32'h0000_00DE) begin
         errors++;
         $display("FAIL lbu_13: got %h expected 000000de", q);
      end
      load(3'b001, 32'h10, q, s);
      sa |= s;
      checks++;
      if (q !== 32'hFFFF_BEEF) begin
         errors++;
         $display("FAIL lh_10: got %h expected ffffbeef", q);
      end
      load(3'b101, 32'h10, q, s);
      sa |= s;
      checks++;
      if (q !== 32'h0000_BEEF) begin
         errors++;
         $display("FAIL lhu_10: got %h expected 0000beef", q);
      end
      load(3'b001, 32'h12, q, s);
      sa |= s;
      checks++;
      if (q !== 32'hFFFF_DEAD) begin
         errors++;
         $display("FAIL lh_12: got %h expected ffffdead", q);
      end
      checks++;
      if (sa !== 1'b0) begin
         errors++;
         $display("FAIL aligned_stall: got %b expected 0", sa);
      end
   endtask

   task automatic test_straddle_word();
      logic [31:0] q;
      bit s;
      store(3'b010, 32'h20, 32'h1122_3344, s);
      store(3'b010, 32'h24, 32'h5566_7788, s);
      load(3'b010, 32'h22, q, s);
      checks++;
      if (s !== SPLIT_EN) begin
         errors++;
         $display("FAIL lw22_stall: got %b expected %b", s, SPLIT_EN);
      end
      checks++;
      if (SPLIT_EN && q !== 32'h7788_1122) begin
         errors++;
         $display("FAIL lw22_data: got %h expected 77881122", q);
      end else if (!SPLIT_EN && q !== 32'h3344_1122) begin
         errors++;
         $display("FAIL lw22_data: got %h expected 33441122", q);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] q;
      logic [31:0] exp_a;
      bit s;
      store(3'b001, 32'h7FF, 32'h0000_ABCD, s);
      checks++;
      if (s !== SPLIT_EN) begin
         errors++;
         $display("FAIL sh7ff_stall: got %b expected %b", s, SPLIT_EN);
      end
      load(3'b100, 32'h7FF, q, s);
      checks++;
      if (q !== 32'h0000_00CD) begin
         errors++;
         $display("FAIL lbu_7ff: got %h expected 000000cd", q);
      end
      exp_a = SPLIT_EN ? 32'h0 : 32'h7FC;
      load(3'b100, exp_a, q, s);
      checks++;
      if (q !== 32'h0000_00AB) begin
         errors++;
         $display("FAIL lbu_hi: got %h expected 000000ab", q);
      end
      load(3'b101, 32'h7FF, q, s);
      checks++;
      if (q !== 32'h0000_ABCD) begin
         errors++;
         $display("FAIL lhu_7ff: got %h expected 0000abcd", q);
      end
   endtask

   task automatic test_io();
      logic [31:0] q;
      bit s;
      io_sw = 32'h0001_F00F;
      store(3'b000, 32'h7001, 32'h0000_005A, s);
      checks++;
      if (io_ledr !== 32'h0000_5A00) begin
         errors++;
         $display("FAIL ledr_sb: got %h expected 00005a00", io_ledr);
      end
      load(3'b010, 32'h7000, q, s);
      checks++;
      if (q !== 32'h0000_5A00) begin
         errors++;
         $display("FAIL ledr_lw: got %h expected 00005a00", q);
      end
      load(3'b010, 32'h7800, q, s);
      checks++;
      if (q !== 32'h0001_F00F) begin
         errors++;
         $display("FAIL sw_lw: got %h expected 0001f00f", q);
      end
      store(3'b010, 32'h7800, 32'hFFFF_FFFF, s);
      store(3'b010, 32'h4000, 32'h1234_5678, s);
      checks++;
      if (io_ledr !== 32'h0000_5A00) begin
         errors++;
         $display("FAIL ledr_keep: got %h expected 00005a00", io_ledr);
      end
      load(3'b010, 32'h4000, q, s);
      checks++;
      if (q !== 32'h0) begin
         errors++;
         $display("FAIL unmapped: got %h expected 0", q);
      end
   endtask

   task automatic test_both_enables();
      logic [31:0] q;
      bit s;
      @(negedge clk);
      bus.mem_rdenM = 1'b1;
      bus.mem_wrenM = 1'b1;
      bus.funct3M = 3'b010;
      bus.alu_dataM = 32'h30;
      bus.st_dataM = 32'hCAFE_F00D;
      #1;
      checks++;
      if (bus.ld_dataM !== 32'h0) begin
         errors++;
         $display("FAIL both_ld: got %h expected 0", bus.ld_dataM);
      end
      @(posedge clk);
      #1;
      idle();
      load(3'b010, 32'h30, q, s);
      checks++;
      if (q !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL both_st: got %h expected cafef00d", q);
      end
   endtask

   task automatic test_abort();
      logic [31:0] q;
      bit s;
      @(negedge clk);
      bus.mem_rdenM = 1'b1;
      bus.funct3M = 3'b010;
      bus.alu_dataM = 32'h22;
      #1;
      checks++;
      if (bus.stallM !== SPLIT_EN) begin
         errors++;
         $display("FAIL abort_stall: got %b expected %b",
                  bus.stallM, SPLIT_EN);
      end
      @(posedge clk);
      #1;
      aclr = 1'b0;
      idle();
      #1;
      checks++;
      if (bus.stallM !== 1'b0) begin
         errors++;
         $display("FAIL abort_rst_stall: got %b expected 0", bus.stallM);
      end
      checks++;
      if (io_ledr !== 32'h0) begin
         errors++;
         $display("FAIL abort_ledr: got %h expected 0", io_ledr);
      end
      @(negedge clk);
      aclr = 1'b1;
      load(3'b010, 32'h20, q, s);
      checks++;
      if (q !== 32'h1122_3344 || s !== 1'b0) begin
         errors++;
         $display("FAIL abort_lw20: got %h/%b expected 11223344/0", q, s);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      aclr = 1'b0;
      io_sw = '0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      aclr = 1'b1;
      test_aligned();
      test_straddle_word();
      test_wrap();
      test_io();
      test_both_enables();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_memory_stage.md
Name: lsu_memory_stage

Overview:
- Memory-stage load/store unit of the 5-stage RV32I pipeline. It sits between the EX/MEM register and the MEM/WB register.
- Holds the data memory and the LEDR/SW memory-mapped registers.
- Produces ld_dataM for MEM/WB and stallM for the hazard unit.
- Handles loads and stores that straddle a word boundary by splitting them into two aligned cycles.

Parameters:
- DMEM_WORDS, 512, data memory depth in 32-bit words (2 KiB); must be a power of two.
- IO_LEDR_ADDR, 32'h0000_7000, LEDR output register address.
- IO_SW_ADDR, 32'h0000_7800, SW input address (read-only).

Ports:
- clk  in  1  clock
- aclr  in  1  asynchronous active-low reset
- mem_rdenM  in  1  load in MEM
- mem_wrenM  in  1  store in MEM
- funct3M  in  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- alu_dataM  in  32  effective byte address
- st_dataM  in  32  store data (rs2)
- io_sw  in  32  switch inputs
- ld_dataM  out  32  extended load result, valid when stallM=0
- stallM  out  1  high while the first half of a split access is in progress
- io_ledr  out  32  LEDR register

Behaviour:
- Reset: aclr low, asynchronous. state=IDLE, hold_q=0, io_ledr=0, stallM=0. ld_dataM follows the combinational path. Memory contents are not reset. aclr during SPLIT aborts the access; any first-half store already written stays written.
- Region decode:
  - DMEM when alu_dataM < DMEM_WORDS*4.
  - LEDR at IO_LEDR_ADDR[31:2]; SW at IO_SW_ADDR[31:2].
  - Anything else is unmapped: loads return 0, stores are ignored.
- Read/write timing: reads are combinational, so a load result appears in the same cycle. Writes commit at posedge clk with per-byte enables: SB 1 byte, SH 2 bytes, SW 4 bytes at lane alu_dataM[1:0].
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- mem_rdenM and mem_wrenM both high is illegal; the store takes priority and ld_dataM=0.
- Straddle: LW/SW with addr[1:0]≠0, or LH/SH with addr[1:0]=3, in DMEM only. IO accesses never split; lanes wrap within the word.
- FSM IDLE:
  - Non-straddle access: single cycle, stallM=0.
  - Straddle access: stallM=1 combinationally. Low-word bytes (word w) are read into hold_q, or written for a store. Go to SPLIT.
- FSM SPLIT:
  - Upper bytes come from word (w+1) mod DMEM_WORDS, so the last word wraps to word 0.
  - Load: ld_dataM = extend(bytes concatenated from hold_q and word w+1).
  - Store: write the upper bytes.
  - stallM=0; return to IDLE.
- Upstream holds EX/MEM stable while stallM=1; the hazard unit inserts a MEM/WB bubble. Inputs in SPLIT are guaranteed identical to the IDLE cycle.
- LEDR:
  - Stores update io_ledr with byte enables.
  - Loads read back io_ledr.
  - SW loads return io_sw sampled combinationally.
  - SW stores are ignored.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined: straddle splitting as above.
- Undefined: no SPLIT state; stallM tied 0. Straddling accesses use the word-aligned-down address: bytes wrap within word w, nothing touches w+1.

Decomposition:
- Shared package lsu_pkg:
  - funct3 access-type enum
  - lsu_state_e {IDLE, SPLIT}
  - default address-map constants
  - byte-enable generation function
- One sub-module, lsu_dmem: byte-enabled write array, DMEM_WORDS×32, with two combinational read ports (w and w+1).
- Lane extraction and extension stay in lsu_memory_stage.

Test Plan:
- SW 0xDEADBEEF @0x10, then LB/LBU @0x13 → ld_dataM 0xFFFFFFDE / 0x000000DE; LH @0x10 → 0xFFFFBEEF; stallM=0 throughout.
- SW 0x11223344 @0x20, SW 0x55667788 @0x24; LW @0x22 → stallM=1 for one cycle, then ld_dataM=0x77881122.
- SH 0xABCD @0x7FF (last byte of DMEM) → two cycles; byte 0x7FF=0xCD, byte 0x000=0xAB (wrap). LHU @0x7FF → 0x0000ABCD.
- SB 0x5A @IO_LEDR_ADDR+1 → io_ledr=0x00005A00; io_sw=0x0001F00F, LW @IO_SW_ADDR → 0x0001F00F; LW @0x4000 → 0.
- Start LW @0x22 and pulse aclr low during SPLIT → stallM=0, state IDLE, io_ledr=0; next LW @0x20 returns 0x11223344.
- Build without LSU_MISALIGN_SPLIT_EN: LW @0x22 → stallM never 1, ld_dataM=0x33441122.
